sprite_blitter: RTL
===================

# sprite_blitter

Copies one rectangular sprite from the sprite-sheet SRAM into the frame buffer. It sits directly downstream of the draw-index-to-sheet-coordinate lookup and consumes its sheet start X/Y, plus a width, a height and a screen destination. It walks the rectangle in raster order, issues one SRAM read per cycle, and writes each returned pixel to the frame buffer. Pixels equal to the transparency key are skipped, and pixels that fall off-screen are clipped.

## Interface
- SHEET_W, 640: sprite-sheet row stride in pixels.
- SCREEN_W, 640 / SCREEN_H, 480: frame-buffer dimensions.
- READ_LAT, 2: SRAM read latency in cycles, counted from address to data; 1 to 4.
- KEY, 16'h0000: transparent colour.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  single-cycle request; honoured only in IDLE.
- SRAM_ADDR_X_Start, SRAM_ADDR_Y_Start  in  11  sheet origin of the sprite.
- Sprite_W, Sprite_H  in  10  sprite size in pixels; each 0 to 640.
- Dest_X, Dest_Y  in  10  screen position of the sprite's top-left pixel.
- SRAM_Addr  out  20  sheet word address; equals y*SHEET_W + x.
- SRAM_Re  out  1  read strobe.
- SRAM_Data  in  16  pixel; valid READ_LAT cycles after its SRAM_Re.
- FB_We  out  1  frame-buffer write enable.
- FB_Addr  out  19  dest_y*SCREEN_W + dest_x.
- FB_Data  out  16  pixel to write.
- Busy  out  1  high while an operation is in flight.
- Done  out  1  one-cycle completion pulse.

## Operation
- State machine: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - Start latches all inputs.
  - Next state is RUN.
  - If Sprite_W = 0 or Sprite_H = 0, next state is DONE instead, with no reads issued.
- RUN:
  - Each cycle asserts SRAM_Re with the current address.
  - Column increments each cycle. At column = W-1 the column wraps to 0 and the row increments.
  - After issuing (W-1, H-1), next state is DRAIN.
- DRAIN: waits until the delay line is empty, then moves to DONE.
- DONE:
  - Done = 1 for one cycle; Busy = 1 in this cycle as well.
  - Next state is IDLE.
- Address generation is incremental, with no multiplier:
  - Sheet row-base register starts at Y_Start*SHEET_W and adds SHEET_W per row; the column is added to it.
  - Frame-buffer row base works the same way with SCREEN_W.
- Each read carries its dest x/y and a valid bit through a READ_LAT-deep delay line.
- The write is registered and occurs one cycle after the data returns.
- FB_We = valid && SRAM_Data != KEY && dest_x < SCREEN_W && dest_y < SCREEN_H.
- When FB_We = 0, FB_Addr and FB_Data hold their previous values.
- Clipped and keyed pixels are still read, so timing is independent of content.
- Start outside IDLE is ignored; latched operands do not change.
- The frame-buffer write path has no backpressure; every write is accepted.

## Timing
- Start is sampled in cycle 0. The first SRAM_Re is in cycle 1. Let N = W*H; the last SRAM_Re is in cycle N.
- The read issued in cycle k produces its FB_We slot in cycle k+READ_LAT+1.
- The last write slot is cycle N+READ_LAT+1, and Done is cycle N+READ_LAT+2.
- Busy is high from cycle 1 through the Done cycle inclusive. A new Start is accepted in the cycle after Done.
- Zero-size request: Done in cycle 1, with no SRAM_Re and no FB_We.
- Reset (asynchronous, at any time, including mid-RUN):
  - State goes to IDLE and the delay line is cleared.
  - All outputs go to 0: SRAM_Addr, SRAM_Re, FB_We, FB_Addr, FB_Data, Busy, Done.
  - No write is emitted after reset is released.
- SRAM_Addr is reduced modulo 2^20; in-range sheets never wrap.

## Structure
- Package blit_pkg holds:
  - the SHEET_W, SCREEN_W and SCREEN_H constants;
  - the state enum typedef;
  - a struct {valid, dest_x, dest_y} for delay-line entries.
- One sub-module, blit_delay_line: a parameterised READ_LAT-stage shift register of blit_pkg entries, with asynchronous active-low clear.

## Test plan
- Basic copy, READ_LAT=2: sheet (0,481), W=2, H=2, dest (10,20).
  - SRAM_Addr = 307840, 307841, 308480, 308481 in cycles 1–4.
  - FB_Addr = 12810, 12811, 13450, 13451 in cycles 4–7.
  - Done in cycle 8.
- Transparency: same request with the second returned word = KEY → only 3 FB_We pulses; the FB_Addr 12811 write is missing.
- Clipping: dest (639,479), W=2, H=2 → only FB_Addr 307199 is written; Done timing is unchanged (cycle 8).
- Zero size: W=0, H=5 → Done in cycle 1, no SRAM_Re, Busy high for one cycle.
- Start while busy: second Start in cycle 3 with different operands → ignored; output is identical to the basic copy.
- Reset mid-op: Reset_n low in cycle 3 → all outputs 0 immediately. A fresh Start after release runs the basic copy with correct timing.

Source files
------------

// File: rtl/blit_pkg.sv
// Shared constants and types for the sprite blitter: screen/sheet geometry,
// the controller state encoding and the read delay-line entry.
package blit_pkg;

  localparam int SHEET_W  = 640;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // fb_addr travels with the coordinates so the write stage needs no multiply
  typedef struct packed {
    logic        valid;
    logic [10:0] dest_x;
    logic [10:0] dest_y;
    logic [18:0] fb_addr;
  } entry_t;

endpackage

// File: rtl/blit_delay_line.sv
// Fixed-depth shift register that carries each outstanding read's destination
// alongside the SRAM latency; also reports when nothing is in flight.
module blit_delay_line
  import blit_pkg::*;
#(
  parameter int READ_LAT = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  entry_t head,
  output entry_t tail,
  output logic   empty
);

  entry_t stage [READ_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= head;
      for (int i = 1; i < READ_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign tail = stage[READ_LAT-1];

  always_comb begin
    empty = 1'b1;
    for (int i = 0; i < READ_LAT; i++) begin
      if (stage[i].valid) empty = 1'b0;
    end
  end

endmodule

// File: rtl/sprite_blitter.sv
// Copies a rectangle from the sprite sheet into the frame buffer in raster
// order, one read per cycle, skipping key-coloured and off-screen pixels.
module sprite_blitter
  import blit_pkg::*;
#(
  parameter int          READ_LAT = 2,
  parameter logic [15:0] KEY      = 16'h0000
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Start,
  input  logic [10:0] SRAM_ADDR_X_Start,
  input  logic [10:0] SRAM_ADDR_Y_Start,
  input  logic [9:0]  Sprite_W,
  input  logic [9:0]  Sprite_H,
  input  logic [9:0]  Dest_X,
  input  logic [9:0]  Dest_Y,
  output logic [19:0] SRAM_Addr,
  output logic        SRAM_Re,
  input  logic [15:0] SRAM_Data,
  output logic        FB_We,
  output logic [18:0] FB_Addr,
  output logic [15:0] FB_Data,
  output logic        Busy,
  output logic        Done
);

  state_t      state;
  logic [9:0]  w_m1, h_m1, col, row;
  logic [19:0] sheet_row, start_sheet;
  logic [18:0] fb_row, fb_cur, start_fb;
  logic [10:0] dx0, dx_cur, dy_cur;
  logic        zero_size, launch, wrap, last, advance, drained, write_ok;
  entry_t      head, tail;

  assign zero_size   = (Sprite_W == 10'd0) || (Sprite_H == 10'd0);
  assign launch      = (state == IDLE) && Start && !zero_size;
  assign wrap        = (col == w_m1);
  assign last        = wrap && (row == h_m1);
  assign advance     = (state == RUN) && !last;
  assign start_sheet = 20'(SRAM_ADDR_Y_Start) * 20'(SHEET_W) + 20'(SRAM_ADDR_X_Start);
  assign start_fb    = 19'(Dest_Y) * 19'(SCREEN_W) + 19'(Dest_X);

  // Control: state, read strobe/address and status flags
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      SRAM_Re   <= 1'b0;
      SRAM_Addr <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            Busy <= 1'b1;
            if (zero_size) begin
              state <= DONE;
              Done  <= 1'b1;
            end else begin
              state     <= RUN;
              SRAM_Re   <= 1'b1;
              SRAM_Addr <= start_sheet;
            end
          end
        end
        RUN: begin
          if (last) begin
            state   <= DRAIN;
            SRAM_Re <= 1'b0;
          end else begin
            SRAM_Addr <= wrap ? sheet_row + 20'(SHEET_W) : SRAM_Addr + 20'd1;
          end
        end
        DRAIN: begin
          if (drained) begin
            state <= DONE;
            Done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          Done  <= 1'b0;
          Busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Walk counters and incremental row bases; reloaded on every launch
  always_ff @(posedge Clk) begin
    if (launch) begin
      w_m1      <= Sprite_W - 10'd1;
      h_m1      <= Sprite_H - 10'd1;
      col       <= '0;
      row       <= '0;
      sheet_row <= start_sheet;
      fb_row    <= start_fb;
      fb_cur    <= start_fb;
      dx0       <= 11'(Dest_X);
      dx_cur    <= 11'(Dest_X);
      dy_cur    <= 11'(Dest_Y);
    end else if (advance) begin
      if (wrap) begin
        col       <= '0;
        row       <= row + 10'd1;
        sheet_row <= sheet_row + 20'(SHEET_W);
        fb_row    <= fb_row + 19'(SCREEN_W);
        fb_cur    <= fb_row + 19'(SCREEN_W);
        dx_cur    <= dx0;
        dy_cur    <= dy_cur + 11'd1;
      end else begin
        col    <= col + 10'd1;
        fb_cur <= fb_cur + 19'd1;
        dx_cur <= dx_cur + 11'd1;
      end
    end
  end

  assign head = '{valid: SRAM_Re, dest_x: dx_cur, dest_y: dy_cur, fb_addr: fb_cur};

  blit_delay_line #(.READ_LAT(READ_LAT)) u_delay (
    .clk   (Clk),
    .rst_n (Reset_n),
    .head  (head),
    .tail  (tail),
    .empty (drained)
  );

  assign write_ok = tail.valid && (SRAM_Data != KEY) &&
                    (tail.dest_x < 11'(SCREEN_W)) && (tail.dest_y < 11'(SCREEN_H));

  // Write stage: one cycle after data returns; address/data hold when idle
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      FB_We   <= 1'b0;
      FB_Addr <= '0;
      FB_Data <= '0;
    end else begin
      FB_We <= write_ok;
      if (write_ok) begin
        FB_Addr <= tail.fb_addr;
        FB_Data <= SRAM_Data;
      end
    end
  end

endmodule
